score_tick_counter: RTL and testbench
=====================================

# score_tick_counter

Game-score counter for the copter game datapath. A free-running clock divider and a rising-edge pulse detector produce a slow tick. A three-state run controller counts that tick into a 32-bit score while the game runs and freezes the score at game over. The score output drives the HEX display formatter.

## Interface

Parameters:
- RATE, default 25; selects the divider bit used as the tick source. Legal range is 0..31. Tick period is 2^(RATE+1) clk cycles.

Ports:
- clk  input  1  system clock (CLOCK_50 domain); all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- start  input  1  level; begins scoring when sampled high in IDLE.
- gameover  input  1  level; ends scoring when sampled high in RUN.
- score  output  32  current score, unsigned, registered.

## Operation

- **Divider**
  - 32-bit register div; cleared by reset; increments by 1 every clk; wraps 2^32-1 -> 0.
  - Tick source is src = div[RATE].
- **Edge detector**
  - Register prev samples src every clk; cleared by reset.
  - incr = src & ~prev (combinational). It is high for exactly one clk per rising edge of src.
  - A held-high src never produces more than one pulse.
- **Controller states:** IDLE, RUN, OVER. Reset state is IDLE.
  - IDLE: if start, go to RUN; otherwise stay.
  - RUN: if gameover, go to OVER; otherwise stay. start is ignored.
  - OVER: stays in OVER until reset. start and gameover are ignored.
- **Score update**
  - On each clk edge with present state RUN and incr high, score <= score + 1.
  - In all other states or cycles, score holds.
  - The decision uses the present state, not the next state:
    - an incr in the same cycle that start is sampled in IDLE is not counted;
    - an incr in the same cycle that gameover is sampled in RUN is counted.
  - Width: 32 bits, unsigned. Overflow behaviour is set by Configuration.

## Timing

- **Reset values:** div = 0, prev = 0, state = IDLE, score = 0. Reset applies immediately (asynchronously) and is released synchronously on the next clk edge after reset goes high.
- **Reset mid-game** returns to IDLE with score 0; a new start is required.
- **First tick:**
  - src first rises after 2^RATE clk edges following reset release.
  - incr is high during that cycle.
  - score updates on the following edge.
  - Subsequent increments occur every 2^(RATE+1) edges.
- **Latency:**
  - start sampled high -> RUN one clk later.
  - gameover sampled high -> OVER one clk later; at most one further increment can land, on that same edge.
- The divider runs regardless of state, so tick phase is not aligned to start.

## Configuration

- **SCORE_SATURATE_EN defined:** at score = 32'hFFFF_FFFF, further incr pulses leave score unchanged.
- **SCORE_SATURATE_EN undefined:** score wraps from 32'hFFFF_FFFF to 0 on the next counted increment.
- All other behaviour is identical with or without the macro.

## Test plan

Use RATE=2 unless noted (tick period 8 cycles; counted increments land on edges 5, 13, 21, … after reset release).

- **Reset only:** reset low, then high, start=0 for 100 cycles -> score stays 0, state IDLE.
- **Normal run:** start pulsed high for 1 cycle immediately after reset release, gameover=0, run 100 clk edges -> score = 12; consecutive increments exactly 8 cycles apart.
- **Game over:** as in the normal run, but gameover asserted for 1 cycle at edge 45 -> score freezes at 6. It stays 6 for 200 further cycles, including a second start pulse.
- **Simultaneous events:**
  - start asserted in the cycle where incr is high -> that tick is not counted.
  - gameover asserted in the cycle where incr is high -> that tick is counted.
- **Async reset mid-run:** reset driven low between clk edges while score = 5 -> score = 0 and state IDLE immediately, without waiting for a clock edge.
- **Overflow:** force score to 32'hFFFF_FFFF in RUN, then one tick -> score = 0 without SCORE_SATURATE_EN; 32'hFFFF_FFFF with it.

Source files
------------

// File: rtl/score_tick_counter_if.sv
// rtl/score_tick_counter_if.sv - game-control and score bundle between the copter game FSM and the score counter
interface score_tick_counter_if;
    logic        start;
    logic        gameover;
    logic [31:0] score;

    modport master (output start, output gameover, input score);
    modport slave  (input start, input gameover, output score);
endinterface

// File: rtl/score_tick_counter.sv
// rtl/score_tick_counter.sv - slow-tick game score counter with IDLE/RUN/OVER control; SCORE_SATURATE_EN selects saturate vs wrap
module score_tick_counter #(
    parameter int unsigned RATE = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    score_tick_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] div_q, div_d;
    logic        prev_q, prev_d;
    logic [31:0] score_q, score_d;
    logic        src;
    logic        incr;

    assign src  = div_q[RATE];
    assign incr = src & ~prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= 32'd0;
            prev_q  <= 1'b0;
            score_q <= 32'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            prev_q  <= prev_d;
            score_q <= score_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q + 32'd1;
        prev_d  = src;
        score_d = score_q;

        case (state_q)
            IDLE:    if (bus.start)    state_d = RUN;
            RUN:     if (bus.gameover) state_d = OVER;
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase

        // Counting keys off the present state, so a tick coincident with gameover still lands.
        if (state_q == RUN && incr) begin
`ifdef SCORE_SATURATE_EN
            if (score_q != 32'hFFFF_FFFF) begin
                score_d = score_q + 32'd1;
            end
`else
            score_d = score_q + 32'd1;
`endif
        end
    end

    assign bus.score = score_q;

endmodule

// File: tb/tb_score_tick_counter.sv
// tb/tb_score_tick_counter.sv - randomized and directed bench for score_tick_counter against an edge-count score model
module tb_score_tick_counter;

    localparam int unsigned RATE = 2;
    localparam int unsigned PER  = 1 << (RATE + 1);
    localparam int unsigned HALF = 1 << RATE;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    score_tick_counter_if bus ();

    score_tick_counter #(.RATE(RATE)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: m_cnt is the number of edges since reset release; mode 0=idle 1=run 2=over.
    int unsigned m_cnt;
    int          m_mode;
    logic [31:0] m_score;

    task automatic model_reset();
        m_cnt   = 0;
        m_mode  = 0;
        m_score = 32'd0;
    endtask

    task automatic model_edge(input logic st, input logic go);
        bit tick;
        tick = ((m_cnt % PER) == HALF);
        if (m_mode == 1 && tick) begin
`ifdef SCORE_SATURATE_EN
            if (m_score != 32'hFFFF_FFFF) m_score = m_score + 32'd1;
`else
            m_score = m_score + 32'd1;
`endif
        end
        if (m_mode == 0 && st) m_mode = 1;
        else if (m_mode == 1 && go) m_mode = 2;
        m_cnt++;
    endtask

    task automatic step(input logic st, input logic go);
        bus.start    = st;
        bus.gameover = go;
        model_edge(st, go);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.gameover = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.gameover = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.score !== 32'd0) begin
            bad++;
            $display("FAIL reset_hold: score=%0d expected 0", bus.score);
        end
        rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 100; k++) begin
            step(1'b0, 1'b0);
            total++;
            if (bus.score !== m_score) begin
                bad++;
                $display("FAIL reset_idle edge %0d: score=%0d expected %0d", k, bus.score, m_score);
            end
        end
        total++;
        if (bus.score !== 32'd0) begin
            bad++;
            $display("FAIL reset_final: score=%0d expected 0", bus.score);
        end
    endtask

    task automatic test_normal_run();
        int          last_edge;
        logic [31:0] prev_score;
        last_edge  = -1;
        prev_score = 32'd0;
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            step(k == 1, 1'b0);
            total++;
            if (bus.score !== m_score) begin
                bad++;
                $display("FAIL normal_run edge %0d: score=%0d expected %0d", k, bus.score, m_score);
            end
            if (bus.score !== prev_score) begin
                total++;
                if (last_edge < 0) begin
                    if (k != 5) begin
                        bad++;
                        $display("FAIL first_tick: landed on edge %0d expected edge 5", k);
                    end
                end else if (k - last_edge != int'(PER)) begin
                    bad++;
                    $display("FAIL tick_spacing: %0d edges expected %0d", k - last_edge, PER);
                end
                last_edge  = k;
                prev_score = bus.score;
            end
        end
        total++;
        if (bus.score !== 32'd12) begin
            bad++;
            $display("FAIL normal_run_final: score=%0d expected 12", bus.score);
        end
    endtask

    task automatic test_game_over();
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            step(k == 1, k == 45);
            total++;
            if (bus.score !== m_score) begin
                bad++;
                $display("FAIL game_over edge %0d: score=%0d expected %0d", k, bus.score, m_score);
            end
        end
        for (int k = 1; k <= 200; k++) begin
            step(k == 50, 1'b0);
            total++;
            if (bus.score !== m_score) begin
                bad++;
                $display("FAIL over_hold cycle %0d: score=%0d expected %0d", k, bus.score, m_score);
            end
        end
        total++;
        if (bus.score !== 32'd6) begin
            bad++;
            $display("FAIL game_over_final: score=%0d expected 6", bus.score);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step(k == 5, k == 21);
            total++;
            if (bus.score !== m_score) begin
                bad++;
                $display("FAIL simultaneous edge %0d: score=%0d expected %0d", k, bus.score, m_score);
            end
            if (k == 12) begin
                total++;
                if (bus.score !== 32'd0) begin
                    bad++;
                    $display("FAIL start_with_tick: score=%0d expected 0", bus.score);
                end
            end
        end
        total++;
        if (bus.score !== 32'd2) begin
            bad++;
            $display("FAIL gameover_with_tick: score=%0d expected 2", bus.score);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 1; k <= 37; k++) step(k == 1, 1'b0);
        total++;
        if (bus.score !== 32'd5) begin
            bad++;
            $display("FAIL async_pre: score=%0d expected 5", bus.score);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.score !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: score=%0d expected 0 before clock edge", bus.score);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b0);
            total++;
            if (bus.score !== m_score) begin
                bad++;
                $display("FAIL after_async edge %0d: score=%0d expected %0d", k, bus.score, m_score);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp13;
        logic [31:0] exp21;
`ifdef SCORE_SATURATE_EN
        exp13 = 32'hFFFF_FFFF;
        exp21 = 32'hFFFF_FFFF;
`else
        exp13 = 32'd0;
        exp21 = 32'd1;
`endif
        do_reset();
        for (int k = 1; k <= 6; k++) step(k == 1, 1'b0);
        force dut.score_q = 32'hFFFF_FFFF;
        #1;
        release dut.score_q;
        m_score = 32'hFFFF_FFFF;
        total++;
        if (bus.score !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL overflow_preload: score=%h expected ffffffff", bus.score);
        end
        for (int k = 7; k <= 21; k++) begin
            step(1'b0, 1'b0);
            total++;
            if (bus.score !== m_score) begin
                bad++;
                $display("FAIL overflow edge %0d: score=%h expected %h", k, bus.score, m_score);
            end
            if (k == 13) begin
                total++;
                if (bus.score !== exp13) begin
                    bad++;
                    $display("FAIL overflow_tick: score=%h expected %h", bus.score, exp13);
                end
            end
        end
        total++;
        if (bus.score !== exp21) begin
            bad++;
            $display("FAIL overflow_next: score=%h expected %h", bus.score, exp21);
        end
    endtask

    task automatic test_random();
        logic st;
        logic go;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int k = 1; k <= 200; k++) begin
                st = ($urandom_range(0, 7) == 0);
                go = ($urandom_range(0, 39) == 0);
                step(st, go);
                total++;
                if (bus.score !== m_score) begin
                    bad++;
                    $display("FAIL random round %0d edge %0d: score=%0d expected %0d", r, k, bus.score, m_score);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_game_over();
        test_simultaneous();
        test_async_reset();
        test_overflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
